// File: rtl/ofm_result_checker.sv
// ofm_result_checker: scans an OFM RAM region after a CNN run and compares it lane-wise against a golden RAM.
// Latency: done pulses B + RD_LATENCY + 2 cycles after start (B = beats); 2 cycles when num_elem == 0.
// Backpressure: none; one beat is issued per cycle, the RAMs must return data exactly RD_LATENCY cycles later.
//
// Ports:
//   clk, rst_n            clock; synchronous reset, active high despite the name
//   start + config        ofm_base, gold_base, num_elem, tol, stop_on_first sampled on an accepted start
//   ofm_rd_*, gold_rd_*   read-only ports into the OFM and golden RAMs (lane k = bits [k*DW +: DW])
//   busy, done, pass      scan status; done is a one-cycle pulse
//   err_count, first_err_* results, held until the next accepted start
module ofm_result_checker #(
  parameter int DATA_WIDTH      = 64,
  parameter int LANES           = 16,
  parameter int OFM_ADDR_WIDTH  = 22,
  parameter int GOLD_ADDR_WIDTH = 16,
  parameter int CNT_WIDTH       = 24,
  parameter int RD_LATENCY      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [OFM_ADDR_WIDTH-1:0]   ofm_base,
  input  logic [GOLD_ADDR_WIDTH-1:0]  gold_base,
  input  logic [CNT_WIDTH-1:0]        num_elem,
  input  logic [DATA_WIDTH-1:0]       tol,
  input  logic                        stop_on_first,
  output logic                        ofm_rd_en,
  output logic [OFM_ADDR_WIDTH-1:0]   ofm_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] ofm_rd_data,
  output logic                        gold_rd_en,
  output logic [GOLD_ADDR_WIDTH-1:0]  gold_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] gold_rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CNT_WIDTH-1:0]        err_count,
  output logic [CNT_WIDTH-1:0]        first_err_idx,
  output logic [DATA_WIDTH-1:0]       first_err_got,
  output logic [DATA_WIDTH-1:0]       first_err_exp
);

  localparam int PW = $clog2(LANES + 1);
  localparam logic [CNT_WIDTH-1:0] LANES_C = CNT_WIDTH'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                     state_q;
  logic                       rd_en_q;
  logic [OFM_ADDR_WIDTH-1:0]  ofm_addr_q;
  logic [GOLD_ADDR_WIDTH-1:0] gold_addr_q;
  logic [CNT_WIDTH-1:0]       beat_q;
  logic [CNT_WIDTH-1:0]       last_beat_q;
  logic [CNT_WIDTH-1:0]       last_cnt_q;
  logic [DATA_WIDTH-1:0]      tol_q;
  logic                       stop_q;
  logic                       busy_q, done_q, pass_q, found_q;
  logic [CNT_WIDTH-1:0]       err_q, first_idx_q;
  logic [DATA_WIDTH-1:0]      first_got_q, first_exp_q;

  // Read pipeline: tracks which beat (and which lanes of it) the RAM data belongs to.
  logic [RD_LATENCY-1:0]      pipe_vld_q;
  logic [CNT_WIDTH-1:0]       pipe_beat_q [RD_LATENCY];
  logic [LANES-1:0]           pipe_mask_q [RD_LATENCY];

  // Beat count and number of live lanes in the last beat, derived from num_elem at start.
  logic [CNT_WIDTH-1:0] cfg_rem, cfg_nbeats, cfg_last_cnt;
  assign cfg_rem      = num_elem % LANES_C;
  assign cfg_nbeats   = (num_elem / LANES_C) + CNT_WIDTH'(cfg_rem != '0);
  assign cfg_last_cnt = (cfg_rem == '0) ? LANES_C : cfg_rem;

  logic [DATA_WIDTH-1:0] got_w [LANES];
  logic [DATA_WIDTH-1:0] exp_w [LANES];
  logic [LANES-1:0]      mism;
  logic [LANES-1:0]      issue_mask;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_WIDTH:0] diff, mag;
    assign got_w[k] = ofm_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign exp_w[k] = gold_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    // One extra bit so the signed difference can never wrap.
    assign diff = {got_w[k][DATA_WIDTH-1], got_w[k]} - {exp_w[k][DATA_WIDTH-1], exp_w[k]};
    assign mag  = diff[DATA_WIDTH] ? -diff : diff;
    assign mism[k] = pipe_vld_q[RD_LATENCY-1] && pipe_mask_q[RD_LATENCY-1][k] &&
                     (mag > {1'b0, tol_q});
    // Only the final beat can be partial.
    assign issue_mask[k] = (beat_q != last_beat_q) || (CNT_WIDTH'(k) < last_cnt_q);
  end

  logic [PW-1:0]          pop;
  logic [CNT_WIDTH-1:0]   first_lane;
  logic [DATA_WIDTH-1:0]  first_got, first_exp;

  // Scanning downward leaves the lowest mismatching lane selected.
  always_comb begin
    pop        = '0;
    first_lane = '0;
    first_got  = '0;
    first_exp  = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      pop = pop + PW'(mism[k]);
      if (mism[k]) begin
        first_lane = CNT_WIDTH'(k);
        first_got  = got_w[k];
        first_exp  = exp_w[k];
      end
    end
  end

  logic [CNT_WIDTH:0]   err_sum;
  logic [CNT_WIDTH-1:0] err_d;
  logic                 stop_hit;
  assign err_sum  = {1'b0, err_q} + (CNT_WIDTH+1)'(pop);
  assign err_d    = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
  assign stop_hit = stop_q && (|mism);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      ofm_addr_q  <= '0;
      gold_addr_q <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      last_cnt_q  <= '0;
      tol_q       <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= '0;
      first_idx_q <= '0;
      first_got_q <= '0;
      first_exp_q <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_beat_q[i] <= '0;
        pipe_mask_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      pipe_vld_q[0]  <= rd_en_q;
      pipe_beat_q[0] <= beat_q;
      pipe_mask_q[0] <= issue_mask;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_beat_q[i] <= pipe_beat_q[i-1];
        pipe_mask_q[i] <= pipe_mask_q[i-1];
      end

      if (|mism) begin
        err_q <= err_d;
        if (!found_q) begin
          found_q     <= 1'b1;
          first_idx_q <= pipe_beat_q[RD_LATENCY-1] * LANES_C + first_lane;
          first_got_q <= first_got;
          first_exp_q <= first_exp;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            ofm_addr_q  <= ofm_base;
            gold_addr_q <= gold_base;
            beat_q      <= '0;
            last_beat_q <= cfg_nbeats - CNT_WIDTH'(1);
            last_cnt_q  <= cfg_last_cnt;
            tol_q       <= tol;
            stop_q      <= stop_on_first;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            found_q     <= 1'b0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
            if (num_elem == '0) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (beat_q == last_beat_q) begin
            rd_en_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            beat_q      <= beat_q + CNT_WIDTH'(1);
            ofm_addr_q  <= ofm_addr_q + OFM_ADDR_WIDTH'(1);
            gold_addr_q <= gold_addr_q + GOLD_ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (pipe_vld_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Early abort: the mismatching beat is counted, everything behind it is dropped.
      if (stop_hit) begin
        pipe_vld_q <= '0;
        rd_en_q    <= 1'b0;
        state_q    <= S_DRAIN;
      end
    end
  end

  assign ofm_rd_en     = rd_en_q;
  assign gold_rd_en    = rd_en_q;
  assign ofm_rd_addr   = ofm_addr_q;
  assign gold_rd_addr  = gold_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_idx_q;
  assign first_err_got = first_got_q;
  assign first_err_exp = first_exp_q;

endmodule

// File: tb/tb_ofm_result_checker.sv
module tb_ofm_result_checker;
  localparam int DW = 64;
  localparam int LN = 16;
  localparam int OB = 5;
  localparam int GB = 33;

  typedef struct {
    logic        pass;
    logic [63:0] err;
    logic [63:0] idx;
    logic [63:0] got;
    logic [63:0] expv;
    int          done_cyc;
    int          reads;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rd_cnt = 0;
  int   act = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  logic [21:0] ofm_base = 22'(OB);
  logic [15:0] gold_base = 16'(GB);
  logic [23:0] num_elem = '0;
  logic [63:0] tol = '0;
  logic        sof = 1'b0;

  logic [LN*DW-1:0] ofm_mem [64];
  logic [LN*DW-1:0] gold_mem [64];

  logic             ren1, gren1, busy1, done1, pass1;
  logic [21:0]      oa1;
  logic [15:0]      ga1;
  logic [LN*DW-1:0] od1, gd1;
  logic [23:0]      err1, fidx1;
  logic [63:0]      fgot1, fexp1;

  logic             ren3, gren3, busy3, done3, pass3;
  logic [21:0]      oa3, oa3a, oa3b;
  logic [15:0]      ga3, ga3a, ga3b;
  logic [LN*DW-1:0] od3, gd3;
  logic [23:0]      err3, fidx3;
  logic [63:0]      fgot3, fexp3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: latency 1 and latency 3.
  always @(posedge clk) begin
    od1  <= ofm_mem[oa1[5:0]];
    gd1  <= gold_mem[ga1[5:0]];
    oa3a <= oa3;
    oa3b <= oa3a;
    ga3a <= ga3;
    ga3b <= ga3a;
    od3  <= ofm_mem[oa3b[5:0]];
    gd3  <= gold_mem[ga3b[5:0]];
  end

  ofm_result_checker #(.DATA_WIDTH(DW), .LANES(LN), .OFM_ADDR_WIDTH(22), .GOLD_ADDR_WIDTH(16),
                       .CNT_WIDTH(24), .RD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst), .start(start1), .ofm_base(ofm_base), .gold_base(gold_base),
    .num_elem(num_elem), .tol(tol), .stop_on_first(sof),
    .ofm_rd_en(ren1), .ofm_rd_addr(oa1), .ofm_rd_data(od1),
    .gold_rd_en(gren1), .gold_rd_addr(ga1), .gold_rd_data(gd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_idx(fidx1), .first_err_got(fgot1), .first_err_exp(fexp1));

  ofm_result_checker #(.DATA_WIDTH(DW), .LANES(LN), .OFM_ADDR_WIDTH(22), .GOLD_ADDR_WIDTH(16),
                       .CNT_WIDTH(24), .RD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst), .start(start3), .ofm_base(ofm_base), .gold_base(gold_base),
    .num_elem(num_elem), .tol(tol), .stop_on_first(sof),
    .ofm_rd_en(ren3), .ofm_rd_addr(oa3), .ofm_rd_data(od3),
    .gold_rd_en(gren3), .gold_rd_addr(ga3), .gold_rd_data(gd3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_idx(fidx3), .first_err_got(fgot3), .first_err_exp(fexp3));

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] r);
    n_total++;
    if (a === r) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, a, r, $time);
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'(i) * 64'h9E37_79B9_7F4A_7C15;
  endfunction

  task automatic fill();
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < LN; k++) begin
        ofm_mem[OB+b][k*DW +: DW]  = pat(b*LN + k);
        gold_mem[GB+b][k*DW +: DW] = pat(b*LN + k);
      end
  endtask

  task automatic set_ofm(input int i, input logic [63:0] v);
    ofm_mem[OB + i/LN][(i%LN)*DW +: DW] = v;
  endtask

  task automatic set_gold(input int i, input logic [63:0] v);
    gold_mem[GB + i/LN][(i%LN)*DW +: DW] = v;
  endtask

  // Scoreboard monitor: checks read addresses as they are issued and results on each done.
  always @(negedge clk) begin
    logic re, dn;
    exp_t e;
    re = (act == 1) ? ren1 : ren3;
    dn = (act == 1) ? done1 : done3;
    if (re) begin
      chk("ofm_rd_addr",  64'((act == 1) ? oa1 : oa3), 64'(OB + rd_cnt));
      chk("gold_rd_addr", 64'((act == 1) ? ga1 : ga3), 64'(GB + rd_cnt));
      rd_cnt++;
    end
    if (dn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc - start_cyc), 64'(e.done_cyc));
        chk("read_count", 64'(rd_cnt), 64'(e.reads));
        chk("pass",       64'((act == 1) ? pass1 : pass3), 64'(e.pass));
        chk("err_count",  64'((act == 1) ? err1 : err3), e.err);
        chk("first_idx",  64'((act == 1) ? fidx1 : fidx3), e.idx);
        chk("first_got",  (act == 1) ? fgot1 : fgot3, e.got);
        chk("first_exp",  (act == 1) ? fexp1 : fexp3, e.expv);
        chk("busy_at_done", 64'((act == 1) ? busy1 : busy3), 64'(0));
      end
    end
  end

  task automatic run(input int inst, input int n, input logic [63:0] t, input logic s,
                     input logic ep, input int ee, input int eidx, input logic [63:0] eg,
                     input logic [63:0] ex, input int edc, input int erd, input bit poke);
    exp_t e;
    e.pass = ep; e.err = 64'(ee); e.idx = 64'(eidx); e.got = eg; e.expv = ex;
    e.done_cyc = edc; e.reads = erd;
    exp_q.push_back(e);
    @(negedge clk);
    act = inst; rd_cnt = 0;
    num_elem = 24'(n); tol = t; sof = s;
    if (inst == 1) start1 = 1'b1; else start3 = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    if (poke) begin
      @(negedge clk);
      num_elem = '0;
      if (inst == 1) start1 = 1'b1; else start3 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'(0));
      void'(exp_q.pop_front());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fill();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_done", 64'(done1), 64'(0));
    chk("rst_pass", 64'(pass1), 64'(0));
    chk("rst_rd_en", 64'(ren1), 64'(0));
    chk("rst_err", 64'(err3), 64'(0));

    // Clean compare, 9 beats.
    run(1, 144, 0, 0, 1, 0, 0, 0, 0, 12, 9, 0);
    // Single error at element 37, exact and with tolerance.
    set_ofm(37, 64'd7); set_gold(37, 64'd5);
    run(1, 144, 0, 0, 0, 1, 37, 64'd7, 64'd5, 12, 9, 0);
    run(1, 144, 64'd2, 0, 1, 0, 0, 0, 0, 12, 9, 0);
    // Partial last beat: garbage beyond element 19 is masked.
    fill();
    for (int i = 20; i < 32; i++) set_ofm(i, ~pat(i));
    run(1, 20, 0, 0, 1, 0, 0, 0, 0, 5, 2, 0);
    set_ofm(19, pat(19) + 64'd5);
    run(1, 20, 0, 0, 0, 1, 19, pat(19) + 64'd5, pat(19), 5, 2, 0);
    // Stop-on-first with RD_LATENCY=3, then full scan.
    fill();
    set_ofm(3, pat(3) + 64'd1); set_ofm(40, pat(40) + 64'd1); set_ofm(41, pat(41) + 64'd1);
    run(3, 144, 0, 1, 0, 1, 3, pat(3) + 64'd1, pat(3), 6, 4, 0);
    run(3, 144, 0, 0, 0, 3, 3, pat(3) + 64'd1, pat(3), 14, 9, 0);
    // Signed tolerance and no wrap at the extremes.
    fill();
    set_ofm(0, -64'sd3); set_gold(0, 64'd2);
    set_ofm(1, 64'h8000_0000_0000_0000); set_gold(1, 64'h7FFF_FFFF_FFFF_FFFF);
    run(1, 2, 64'd4, 0, 0, 2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 4, 1, 0);
    run(1, 1, 64'd5, 0, 1, 0, 0, 0, 0, 4, 1, 0);
    // Empty scan.
    run(1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
    // Start while busy is ignored.
    fill();
    run(1, 144, 0, 0, 1, 0, 0, 0, 0, 12, 9, 1);

    // Reset in the middle of ISSUE.
    @(negedge clk);
    act = 1; rd_cnt = 0; num_elem = 24'd144; tol = '0; sof = 1'b0;
    start1 = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_en", 64'(ren1), 64'(0));
    chk("midrst_busy", 64'(busy1), 64'(0));
    chk("midrst_pass", 64'(pass1), 64'(0));
    chk("midrst_done", 64'(done1), 64'(0));
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_rd_en", 64'(ren1), 64'(0));
    chk("post_rst_busy", 64'(busy1), 64'(0));
    chk("post_rst_reads", 64'(rd_cnt), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
